chip_sequencer: RTL and testbench
=================================

CHIP_SEQUENCER -- requirements
Module: chip_sequencer

Interface
REQ-001 SHALL provide parameter MAX_SF_LOG2, default 4, meaning largest supported log2 spreading factor (SF = 2^sf_log2).
REQ-002 SHALL provide parameter FRAME_W, default 8, meaning width of the frame-length field (frame of 1..2^FRAME_W bits).
REQ-003 SHALL provide i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide i_arst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide i_send  input  1  one-cycle frame start request.
REQ-006 SHALL provide i_chaos_valid  input  1  chaos chip available this cycle; chip advance qualifier.
REQ-007 SHALL provide i_sf_log2  input  $clog2(MAX_SF_LOG2+1)  requested log2 SF, legal 1..MAX_SF_LOG2.
REQ-008 SHALL provide i_frame_len  input  FRAME_W  frame bits minus one.
REQ-009 SHALL provide o_sending  output  1  high while frame active (RUN).
REQ-010 SHALL provide o_chip_index  output  MAX_SF_LOG2+1  chip position within current bit.
REQ-011 SHALL provide o_msb  output  1  0 = reference half, 1 = data half of current bit.
REQ-012 SHALL provide o_load_bit  output  1  combinational: last chip of bit advancing this cycle.
REQ-013 SHALL provide o_bit_index  output  FRAME_W  bit position within frame.
REQ-014 SHALL provide o_done  output  1  one-cycle pulse after last chip of frame.
REQ-015 SHALL provide o_cfg_err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accepted i_send; RUN->DONE on last chip of last bit advancing; DONE->IDLE unconditionally next cycle.
REQ-017 SHALL accept i_send only in IDLE with 1 <= i_sf_log2 <= MAX_SF_LOG2; otherwise i_send ignored, and if in IDLE with illegal SF, o_cfg_err pulses next cycle.
REQ-018 SHALL latch i_sf_log2 and i_frame_len on acceptance; input changes during RUN have no effect.
REQ-019 SHALL have chips per bit = 2^(sf_log2+1); o_chip_index counts 0..2^(sf_log2+1)-1, increments only in RUN with i_chaos_valid high, else holds.
REQ-020 SHALL drive o_msb = o_chip_index[sf_log2] using the latched SF.
REQ-021 SHALL assert o_load_bit when RUN, i_chaos_valid and o_chip_index == 2^(sf_log2+1)-1; chip index wraps to 0 and o_bit_index increments the next cycle.
REQ-022 SHALL enter DONE when o_load_bit is high and o_bit_index == latched frame length; o_done high exactly during DONE; indices return to 0.
REQ-023 SHALL clear o_chip_index and o_bit_index to 0 on acceptance; first advancing chip is index 0.
REQ-024 SHALL ignore i_send in RUN and DONE (no restart, no o_cfg_err).
REQ-025 SHALL hold all counters when i_chaos_valid is low for any number of cycles, with no chip lost or duplicated.

Reset
REQ-026 SHALL on i_arst_n low immediately force IDLE and zero all outputs and counters, including mid-frame; no o_done is produced for an aborted frame.
REQ-027 SHALL reset latched SF to 1 and latched frame length to 0.

Configuration
REQ-028 SHALL with CHIP_SEQ_ABORT_EN defined add input i_abort (1 bit); i_abort high in RUN forces DONE next cycle, with o_done pulsing and counters cleared; ignored in IDLE/DONE; abort beats concurrent o_load_bit.
REQ-029 SHALL without CHIP_SEQ_ABORT_EN have no i_abort port, with frames ending only by completion or reset.

Verification
REQ-030 SHALL cover: sf_log2=1, frame_len=3, i_chaos_valid constant 1, i_send pulse -> o_sending 16 cycles, o_load_bit on every 4th chip, o_msb pattern 0011, o_done one cycle after 16th chip.
REQ-031 SHALL cover: sf_log2=4, frame_len=0, i_chaos_valid toggling 1/0 -> exactly 32 advancing chips, o_msb high for chips 16..31, o_done once.
REQ-032 SHALL cover: i_sf_log2=0 or MAX_SF_LOG2+1 with i_send in IDLE -> o_cfg_err pulse, o_sending stays 0.
REQ-033 SHALL cover: i_send and changed i_sf_log2 mid-frame -> no restart, latched SF used to completion.
REQ-034 SHALL cover: i_arst_n low at bit 2 chip 3 -> all outputs 0 asynchronously, no o_done, next i_send starts from index 0.
REQ-035 SHALL cover with CHIP_SEQ_ABORT_EN: i_abort at bit 1 chip 2 -> o_done next cycle, then IDLE with counters 0.

Source files
------------

// File: rtl/chip_sequencer.sv
// Chip/bit sequencer for a chaos-spread transmitter: walks reference and data chips of every frame bit.
// Optional frame abort input is compiled in with CHIP_SEQ_ABORT_EN.
module chip_sequencer #(
    parameter int MAX_SF_LOG2 = 4,
    parameter int FRAME_W     = 8
) (
    input  logic                             i_clk,
    input  logic                             i_arst_n,
    input  logic                             i_send,
    input  logic                             i_chaos_valid,
    input  logic [$clog2(MAX_SF_LOG2+1)-1:0] i_sf_log2,
    input  logic [FRAME_W-1:0]               i_frame_len,
`ifdef CHIP_SEQ_ABORT_EN
    input  logic                             i_abort,
`endif
    output logic                             o_sending,
    output logic [MAX_SF_LOG2:0]             o_chip_index,
    output logic                             o_msb,
    output logic                             o_load_bit,
    output logic [FRAME_W-1:0]               o_bit_index,
    output logic                             o_done,
    output logic                             o_cfg_err
);

    localparam int SFW    = $clog2(MAX_SF_LOG2 + 1);
    localparam int CHIP_W = MAX_SF_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SFW-1:0]      sf_q;
    logic [FRAME_W-1:0]  len_q;
    logic [CHIP_W-1:0]   chip_q;
    logic [FRAME_W-1:0]  bit_q;
    logic                cfg_err_q;
    logic [CHIP_W-1:0]   chip_last_idx;
    logic                sf_legal;
    logic                accept;
    logic                load_bit;
    logic                last_bit;
    logic                abort_req;

`ifdef CHIP_SEQ_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign sf_legal = (i_sf_log2 != '0) && (i_sf_log2 <= SFW'(MAX_SF_LOG2));
    assign accept   = (state == S_IDLE) && i_send && sf_legal;

    // 2 << sf wraps to zero at the largest SF, so the subtraction still yields all-ones.
    assign chip_last_idx = (CHIP_W'(2) << sf_q) - CHIP_W'(1);
    assign load_bit      = (state == S_RUN) && i_chaos_valid && (chip_q == chip_last_idx);
    assign last_bit      = (bit_q == len_q);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN: begin
                if (abort_req) begin
                    state_nxt = S_DONE;
                end else if (load_bit && last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sf_q      <= SFW'(1);
            len_q     <= '0;
            chip_q    <= '0;
            bit_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state == S_IDLE) && i_send && !sf_legal;
            if (accept) begin
                sf_q   <= i_sf_log2;
                len_q  <= i_frame_len;
                chip_q <= '0;
                bit_q  <= '0;
            end else if (state == S_RUN) begin
                if (abort_req) begin
                    chip_q <= '0;
                    bit_q  <= '0;
                end else if (i_chaos_valid) begin
                    if (load_bit) begin
                        chip_q <= '0;
                        bit_q  <= last_bit ? '0 : bit_q + FRAME_W'(1);
                    end else begin
                        chip_q <= chip_q + CHIP_W'(1);
                    end
                end
            end
        end
    end

    assign o_sending    = (state == S_RUN);
    assign o_done       = (state == S_DONE);
    assign o_cfg_err    = cfg_err_q;
    assign o_chip_index = chip_q;
    assign o_bit_index  = bit_q;
    assign o_msb        = chip_q[sf_q];
    assign o_load_bit   = load_bit;

endmodule

// File: tb/tb_chip_sequencer.sv
// Randomized scoreboard bench for chip_sequencer: expected chip/done/cfg events queued at stimulus time,
// popped by a negedge monitor whenever the DUT advances a chip, pulses done or flags a config error.
module tb_chip_sequencer;

    localparam int MAX_SF = 4;
    localparam int FW     = 8;
    localparam int SFW    = $clog2(MAX_SF + 1);
    localparam int K_CHIP = 0;
    localparam int K_DONE = 1;
    localparam int K_CFG  = 2;

    logic              i_clk = 1'b0;
    logic              i_arst_n = 1'b0;
    logic              i_send = 1'b0;
    logic              i_chaos_valid = 1'b0;
    logic [SFW-1:0]    i_sf_log2 = '0;
    logic [FW-1:0]     i_frame_len = '0;
`ifdef CHIP_SEQ_ABORT_EN
    logic              i_abort = 1'b0;
`endif
    logic              o_sending;
    logic [MAX_SF:0]   o_chip_index;
    logic              o_msb;
    logic              o_load_bit;
    logic [FW-1:0]     o_bit_index;
    logic              o_done;
    logic              o_cfg_err;

    chip_sequencer #(.MAX_SF_LOG2(MAX_SF), .FRAME_W(FW)) dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_send        (i_send),
        .i_chaos_valid (i_chaos_valid),
        .i_sf_log2     (i_sf_log2),
        .i_frame_len   (i_frame_len),
`ifdef CHIP_SEQ_ABORT_EN
        .i_abort       (i_abort),
`endif
        .o_sending     (o_sending),
        .o_chip_index  (o_chip_index),
        .o_msb         (o_msb),
        .o_load_bit    (o_load_bit),
        .o_bit_index   (o_bit_index),
        .o_done        (o_done),
        .o_cfg_err     (o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int kind;
        int chip;
        int bitn;
        int msb;
        int load;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   run_cyc     = 0;
    int   done_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is (len+1) bits of 2^(sf+1) chips; upper half of each bit is the data half.
    task automatic push_frame(input int sf, input int len);
        int cpb;
        cpb = 2 << sf;
        for (int b = 0; b <= len; b++) begin
            for (int c = 0; c < cpb; c++) begin
                exp_q.push_back('{K_CHIP, c, b, (c >= (1 << sf)) ? 1 : 0, (c == cpb - 1) ? 1 : 0});
            end
        end
        exp_q.push_back('{K_DONE, 0, 0, 0, 0});
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (o_sending) run_cyc++;
        if (o_done) done_cnt++;
        if (o_sending && i_chaos_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_chip", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("kind_chip", K_CHIP, e.kind);
                check("chip_index", int'(o_chip_index), e.chip);
                check("bit_index", int'(o_bit_index), e.bitn);
                check("msb", int'(o_msb), e.msb);
                check("load_bit", int'(o_load_bit), e.load);
            end
        end else begin
            check("load_bit_idle", int'(o_load_bit), 0);
        end
        if (o_done) begin
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("kind_done", K_DONE, e.kind);
            end
        end
        if (o_cfg_err) begin
            if (exp_q.size() == 0) check("unexpected_cfg_err", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("kind_cfg_err", K_CFG, e.kind);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic pick_chaos(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2 == 0);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic chk_zero(input string tag);
        check({tag, "_sending"}, int'(o_sending), 0);
        check({tag, "_chip"}, int'(o_chip_index), 0);
        check({tag, "_bit"}, int'(o_bit_index), 0);
        check({tag, "_msb"}, int'(o_msb), 0);
        check({tag, "_load"}, int'(o_load_bit), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_cfg_err"}, int'(o_cfg_err), 0);
    endtask

    task automatic run_frame(input int sf, input int len, input int mode, input bit mid);
        int rb, db, cyc, budget;
        push_frame(sf, len);
        rb = run_cyc;
        db = done_cnt;
        i_send        = 1'b1;
        i_sf_log2     = SFW'(sf);
        i_frame_len   = FW'(len);
        i_chaos_valid = pick_chaos(mode, 0);
        step();
        i_send      = 1'b0;
        i_sf_log2   = SFW'($urandom_range(0, 7));
        i_frame_len = FW'($urandom);
        cyc    = 0;
        budget = (len + 1) * (2 << sf) * 8 + 50;
        while (exp_q.size() != 0 && cyc < budget) begin
            i_chaos_valid = pick_chaos(mode, cyc + 1);
            i_send = (mid && cyc == 3 && exp_q.size() > 1);
            if (i_send) i_sf_log2 = SFW'($urandom_range(0, MAX_SF + 1));
            step();
            cyc++;
        end
        i_send = 1'b0;
        check("frame_complete", exp_q.size(), 0);
        exp_q.delete();
        check("done_once", done_cnt - db, 1);
        if (mode == 0) check("sending_cycles", run_cyc - rb, (len + 1) * (2 << sf));
    endtask

    task automatic cfg_test(input int sf);
        int rb;
        exp_q.push_back('{K_CFG, 0, 0, 0, 0});
        rb            = run_cyc;
        i_send        = 1'b1;
        i_sf_log2     = SFW'(sf);
        i_chaos_valid = 1'b1;
        step();
        i_send = 1'b0;
        step();
        step();
        check("cfg_err_seen", exp_q.size(), 0);
        exp_q.delete();
        check("cfg_no_start", run_cyc - rb, 0);
    endtask

    initial begin
        int cyc, db;
        #3;
        chk_zero("reset");
        #9;
        i_arst_n = 1'b1;
        step();

        run_frame(1, 3, 0, 1'b0);
        run_frame(4, 0, 1, 1'b0);
        cfg_test(0);
        cfg_test(MAX_SF + 1);
        run_frame(2, 2, 0, 1'b1);
        run_frame(1, 1, 2, 1'b1);

        // Async reset in the middle of bit 2, chip 3: frame is dropped without a done pulse.
        push_frame(2, 5);
        db            = done_cnt;
        i_send        = 1'b1;
        i_sf_log2     = SFW'(2);
        i_frame_len   = FW'(5);
        i_chaos_valid = 1'b1;
        step();
        i_send = 1'b0;
        cyc = 0;
        while (!(o_bit_index == 2 && o_chip_index == 3) && cyc < 200) begin
            step();
            cyc++;
        end
        check("reset_point_reached", (cyc < 200) ? 1 : 0, 1);
        #1;
        i_arst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_zero("midframe_reset");
        step();
        step();
        check("no_done_after_reset", done_cnt - db, 0);
        i_arst_n = 1'b1;
        step();
        run_frame(2, 1, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            run_frame($urandom_range(1, MAX_SF), $urandom_range(0, 5),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

`ifdef CHIP_SEQ_ABORT_EN
        push_frame(2, 3);
        i_send        = 1'b1;
        i_sf_log2     = SFW'(2);
        i_frame_len   = FW'(3);
        i_chaos_valid = 1'b1;
        step();
        i_send = 1'b0;
        cyc = 0;
        while (!(o_bit_index == 1 && o_chip_index == 2) && cyc < 200) begin
            step();
            cyc++;
        end
        check("abort_point_reached", (cyc < 200) ? 1 : 0, 1);
        i_chaos_valid = 1'b0;
        i_abort       = 1'b1;
        exp_q.delete();
        exp_q.push_back('{K_DONE, 0, 0, 0, 0});
        step();
        i_abort = 1'b0;
        step();
        check("abort_done_seen", exp_q.size(), 0);
        exp_q.delete();
        chk_zero("after_abort");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
